// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe game-flow stage.
package ttt_pkg;

   localparam int NUM_CELLS = 9;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      X     = 2'b01,
      O     = 2'b10
   } cell_t;

   typedef enum logic [1:0] {
      WAIT   = 2'b00,
      CHECK  = 2'b01,
      SETTLE = 2'b10,
      OVER   = 2'b11
   } state_t;

   function automatic logic [NUM_CELLS-1:0] cell_onehot(input logic [3:0] idx);
      return NUM_CELLS'(1) << idx;
   endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-turn up-counter: counts enabled cycles and pulses done on the last one,
// clearing itself so it never wraps.
module turn_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic done
);

   localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] count;

   assign done = en && (count == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= done ? '0 : count + W'(1);
      end
   end

endmodule

// File: rtl/turn_controller.sv
// Tic-tac-toe game flow: board registers, player turn, turn time limit and
// the handshake with the external illegal-move and win detectors.
//
//   state  | meaning
//   WAIT   | waiting for a move, turn timer running
//   CHECK  | one-hot enable driven, detector verdict sampled at end of cycle
//   SETTLE | board updated, win detector given one cycle to respond
//   OVER   | game finished (win or draw), board frozen, timer stopped
module turn_controller
   import ttt_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 new_game,
   input  logic                 move_valid,
   input  logic [3:0]           move_sel,
   input  logic                 illegal_move,
   input  logic                 game_over,
   output logic [1:0]           pos1,
   output logic [1:0]           pos2,
   output logic [1:0]           pos3,
   output logic [1:0]           pos4,
   output logic [1:0]           pos5,
   output logic [1:0]           pos6,
   output logic [1:0]           pos7,
   output logic [1:0]           pos8,
   output logic [1:0]           pos9,
   output logic [NUM_CELLS-1:0] X_en,
   output logic [NUM_CELLS-1:0] O_en,
   output logic                 turn,
   output logic                 move_ok,
   output logic                 move_err,
   output logic                 timeout,
   output logic                 draw
);

   state_t     state;
   cell_t      board [NUM_CELLS];
   logic [3:0] idx;
   logic [3:0] move_cnt;

   logic timer_clr;
   logic timer_en;
   logic timer_done;

   // A pending request freezes the timer, so an illegal move resumes it unchanged.
   assign timer_clr = new_game || (state == CHECK && !illegal_move);
   assign timer_en  = !new_game && (state == WAIT) && !move_valid;

   turn_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (timer_clr),
      .en   (timer_en),
      .done (timer_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= WAIT;
         for (int k = 0; k < NUM_CELLS; k++) board[k] <= EMPTY;
         idx      <= '0;
         move_cnt <= '0;
         X_en     <= '0;
         O_en     <= '0;
         turn     <= 1'b0;
         move_ok  <= 1'b0;
         move_err <= 1'b0;
         timeout  <= 1'b0;
         draw     <= 1'b0;
      end else begin
         X_en     <= '0;
         O_en     <= '0;
         move_ok  <= 1'b0;
         move_err <= 1'b0;
         timeout  <= 1'b0;
         if (new_game) begin
            state    <= WAIT;
            for (int k = 0; k < NUM_CELLS; k++) board[k] <= EMPTY;
            idx      <= '0;
            move_cnt <= '0;
            turn     <= 1'b0;
            draw     <= 1'b0;
         end else begin
            case (state)
               WAIT: begin
                  if (move_valid) begin
                     if (move_sel <= 4'd8) begin
                        idx   <= move_sel;
                        state <= CHECK;
                        if (turn) O_en <= cell_onehot(move_sel);
                        else      X_en <= cell_onehot(move_sel);
                     end else begin
                        move_err <= 1'b1;
                     end
                  end else if (timer_done) begin
                     timeout <= 1'b1;
                     turn    <= ~turn;
                  end
               end
               CHECK: begin
                  if (illegal_move) begin
                     move_err <= 1'b1;
                     state    <= WAIT;
                  end else begin
                     board[idx] <= turn ? O : X;
                     move_ok    <= 1'b1;
                     turn       <= ~turn;
                     move_cnt   <= move_cnt + 4'd1;
                     state      <= SETTLE;
                  end
               end
               SETTLE: begin
                  if (game_over) begin
                     state <= OVER;
                  end else if (move_cnt == 4'd9) begin
                     draw  <= 1'b1;
                     state <= OVER;
                  end else begin
                     state <= WAIT;
                  end
               end
               OVER: begin
                  state <= OVER;
               end
               default: state <= WAIT;
            endcase
         end
      end
   end

   assign pos1 = board[0];
   assign pos2 = board[1];
   assign pos3 = board[2];
   assign pos4 = board[3];
   assign pos5 = board[4];
   assign pos6 = board[5];
   assign pos7 = board[6];
   assign pos8 = board[7];
   assign pos9 = board[8];

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller with a 20-cycle turn limit.
module tb_turn_controller;
   import ttt_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       new_game;
   logic       move_valid;
   logic [3:0] move_sel;
   logic       illegal_move;
   logic       game_over;
   logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
   logic [8:0] X_en, O_en;
   logic       turn, move_ok, move_err, timeout, draw;
   logic [17:0] board_q;

   int n_cmp = 0;
   int n_err = 0;

   turn_controller #(.TIMEOUT_CYCLES(20)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .new_game    (new_game),
      .move_valid  (move_valid),
      .move_sel    (move_sel),
      .illegal_move(illegal_move),
      .game_over   (game_over),
      .pos1(pos1), .pos2(pos2), .pos3(pos3),
      .pos4(pos4), .pos5(pos5), .pos6(pos6),
      .pos7(pos7), .pos8(pos8), .pos9(pos9),
      .X_en        (X_en),
      .O_en        (O_en),
      .turn        (turn),
      .move_ok     (move_ok),
      .move_err    (move_err),
      .timeout     (timeout),
      .draw        (draw)
   );

   always #5 clk = ~clk;

   assign board_q = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_new_game();
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
   endtask

   // Full legal move: request, CHECK, SETTLE; ends one cycle after SETTLE.
   task automatic do_move(input logic [3:0] sel);
      move_valid = 1'b1;
      move_sel   = sel;
      tick();
      move_valid = 1'b0;
      tick();
      check($sformatf("move_ok_%0d", sel), move_ok, 1);
      tick();
   endtask

   initial begin
      logic seen;
      rst_n        = 1'b0;
      new_game     = 1'b0;
      move_valid   = 1'b0;
      move_sel     = 4'd0;
      illegal_move = 1'b0;
      game_over    = 1'b0;
      tick(2);

      check("rst_board", board_q, 0);
      check("rst_turn", turn, 0);
      check("rst_en", {X_en, O_en}, 0);
      check("rst_pulses", {move_ok, move_err, timeout, draw}, 0);
      check("rst_state", 32'(dut.state), 32'(WAIT));
      rst_n = 1'b1;
      tick();

      // X plays centre
      move_valid = 1'b1; move_sel = 4'd4;
      tick();
      move_valid = 1'b0;
      check("x4_xen", X_en, 9'b000010000);
      check("x4_oen", O_en, 0);
      check("x4_pos5_pre", pos5, 2'b00);
      tick();
      check("x4_xen_off", X_en, 0);
      check("x4_pos5", pos5, 2'b01);
      check("x4_ok", move_ok, 1);
      check("x4_turn", turn, 1);
      tick();
      check("x4_ok_once", move_ok, 0);
      check("x4_state_wait", 32'(dut.state), 32'(WAIT));

      // O tries the occupied centre, detector flags it
      illegal_move = 1'b1;
      move_valid = 1'b1; move_sel = 4'd4;
      tick();
      move_valid = 1'b0;
      check("o4_oen", O_en, 9'b000010000);
      check("o4_xen", X_en, 0);
      tick();
      illegal_move = 1'b0;
      check("o4_err", move_err, 1);
      check("o4_ok", move_ok, 0);
      check("o4_pos5", pos5, 2'b01);
      check("o4_turn", turn, 1);
      check("o4_state", 32'(dut.state), 32'(WAIT));

      // Invalid index holds the timer for one cycle; timeout lands one edge later
      pulse_new_game();
      check("ng_turn", turn, 0);
      tick(5);
      move_valid = 1'b1; move_sel = 4'd12;
      tick();
      move_valid = 1'b0;
      check("inv_err", move_err, 1);
      check("inv_en", {X_en, O_en}, 0);
      tick(14);
      check("inv_no_to_early", timeout, 0);
      tick();
      check("to_pulse", timeout, 1);
      check("to_turn", turn, 1);
      tick();
      check("to_once", timeout, 0);

      // Move on the timeout cycle wins
      pulse_new_game();
      tick(19);
      move_valid = 1'b1; move_sel = 4'd0;
      tick();
      move_valid = 1'b0;
      check("race_no_to", timeout, 0);
      check("race_xen", X_en, 9'b000000001);
      tick();
      check("race_ok", move_ok, 1);
      check("race_pos1", pos1, 2'b01);
      check("race_turn", turn, 1);
      tick();

      // Nine legal moves, no win -> draw
      pulse_new_game();
      do_move(0); do_move(4); do_move(8); do_move(1); do_move(7);
      do_move(6); do_move(2); do_move(5); do_move(3);
      check("draw_flag", draw, 1);
      check("draw_state", 32'(dut.state), 32'(OVER));
      check("draw_board", board_q, 18'b01_01_10_10_10_01_01_10_01);
      check("draw_turn", turn, 1);
      move_valid = 1'b1; move_sel = 4'd0;
      tick();
      move_valid = 1'b0;
      check("over_no_err", move_err, 0);
      check("over_no_en", {X_en, O_en}, 0);
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (move_ok || timeout) seen = 1'b1;
      end
      check("over_silent", seen, 0);
      check("over_draw_sticky", draw, 1);
      pulse_new_game();
      check("ng_board", board_q, 0);
      check("ng_turn2", turn, 0);
      check("ng_draw", draw, 0);
      check("ng_state", 32'(dut.state), 32'(WAIT));

      // Win after the fifth move
      do_move(0); do_move(3); do_move(1); do_move(4);
      move_valid = 1'b1; move_sel = 4'd2;
      tick();
      move_valid = 1'b0;
      tick();
      game_over = 1'b1;
      tick();
      game_over = 1'b0;
      check("win_state", 32'(dut.state), 32'(OVER));
      move_valid = 1'b1; move_sel = 4'd8;
      tick();
      move_valid = 1'b0;
      tick(2);
      check("win_frozen", board_q, 18'b00_00_00_00_10_10_01_01_01);
      check("win_turn", turn, 1);
      check("win_no_draw", draw, 0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_board", board_q, 0);
      check("arst_turn", turn, 0);
      check("arst_state", 32'(dut.state), 32'(WAIT));
      rst_n = 1'b1;
      tick();

      // Reset in the middle of CHECK drops the move
      move_valid = 1'b1; move_sel = 4'd6;
      tick();
      move_valid = 1'b0;
      check("mid_xen", X_en, 9'b001000000);
      #2 rst_n = 1'b0;
      #1;
      check("mid_xen_clr", X_en, 0);
      rst_n = 1'b1;
      tick();
      check("mid_no_ok", move_ok, 0);
      check("mid_board", board_q, 0);
      check("mid_turn", turn, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/turn_controller.md
# turn_controller

Game-flow stage of the tic-tac-toe datapath: owns the 3x3 board registers, the player turn, and a per-turn time limit. It turns a player's cell selection into a one-hot X/O enable for the illegal-move detector, samples that detector's verdict, and commits legal moves to the board. It sits directly upstream of the illegal-move detector and the win detector, and its `game_over` input is fed back from the win detector.

## Interface
- `TIMEOUT_CYCLES`, default 500_000_000: turn time limit in clock cycles (10 s at 50 MHz). Benches override it.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `new_game` in 1: synchronous clear pulse. Has priority over every other input.
- `move_valid` in 1: one-cycle move request, already debounced and synchronized.
- `move_sel` in 4: cell index 0..8 (cell k maps to posk+1). Values 9..15 are invalid.
- `illegal_move` in 1: combinational verdict from the detector on the current `pos*` and `X_en`/`O_en`.
- `game_over` in 1: win-detector flag.
- `pos1`..`pos9` out 2 each: cell contents, 00 empty, 01 X, 10 O. 11 is never produced.
- `X_en`, `O_en` out 9: one-hot move strobe. Bit k corresponds to cell k.
- `turn` out 1: 0 = X to move, 1 = O to move.
- `move_ok`, `move_err`, `timeout` out 1: one-cycle status pulses.
- `draw` out 1: the board is full with no win. Sticky until reset or `new_game`.

## Operation
- The FSM has four states: WAIT, CHECK, SETTLE, OVER.
- **WAIT**
  - The turn timer increments every cycle.
  - `move_valid` with `move_sel` ≤ 8: latch the index and go to CHECK.
  - `move_valid` with `move_sel` > 8: pulse `move_err`, stay in WAIT, and leave the timer untouched.
  - Timer reaches `TIMEOUT_CYCLES`-1 with no `move_valid`: the current player forfeits the turn. Pulse `timeout`, toggle `turn`, and clear the timer. If the same cycle carries `move_valid`, the move takes priority.
- **CHECK** (exactly one cycle)
  - Drive bit idx of `X_en` (turn=0) or `O_en` (turn=1). All other enable bits are 0.
  - Sample `illegal_move` at the end of the cycle.
  - Illegal: pulse `move_err`, return to WAIT, and resume the timer at its held value.
  - Legal: write cell idx (01 for X, 10 for O), pulse `move_ok`, toggle `turn`, increment the move count (0..9), clear the timer, and go to SETTLE.
- **SETTLE** (one cycle): lets `game_over` reflect the new board.
  - `game_over`=1: go to OVER.
  - Otherwise, move count = 9: set `draw` and go to OVER.
  - Otherwise: go to WAIT.
- **OVER**: the board is frozen. `move_valid` is ignored and the timer is stopped.
- `move_valid` arriving in CHECK or SETTLE is dropped, with no pulse.
- `new_game` from any state clears:
  - the board, move count, timer and `draw`;
  - `turn` to 0;
  - the FSM to WAIT.

  Pulses are 0 during the clearing cycle.

## Timing
- All outputs are registered.
- Reset values: `pos*`=00, `X_en`=`O_en`=0, `turn`=0, `move_ok`=`move_err`=`timeout`=0, `draw`=0, state WAIT, timer 0, move count 0.
- Legal move path:
  - `move_valid` sampled at edge n.
  - Enable is high during cycle n+1 (CHECK).
  - `pos`, `turn` and `move_ok` update at edge n+2.
  - The state leaves SETTLE at edge n+3.
  - Move-to-move throughput is 3 cycles minimum.
- Illegal move: `move_err` is high in cycle n+2 and the state is back in WAIT in cycle n+2.
- Invalid index: `move_err` is high in cycle n+1.
- Timeout: `timeout` pulses exactly `TIMEOUT_CYCLES` cycles after the timer cleared, counting only WAIT cycles.
- Timer width is $clog2(`TIMEOUT_CYCLES`). The timer never wraps: it clears on match.
- `rst_n` asserted mid-CHECK drops the move with no pulse and restores all reset values asynchronously.

## Structure
- Package `ttt_pkg`:
  - `cell_t` (EMPTY=2'b00, X=2'b01, O=2'b10);
  - `state_t`;
  - `NUM_CELLS`=9.
- Sub-module `turn_timer`: a parameterized counter with `clr`/`en` inputs and a `done` pulse. Instantiated once.
- The board is stored as an array of `cell_t` and fanned out to `pos1`..`pos9`.

## Test plan
All scenarios use `TIMEOUT_CYCLES`=20.
- Reset, then X selects 4 (legal) → `X_en`=9'b000010000 for one cycle; `pos5`=01, `move_ok` one pulse, `turn`=1.
- O selects 4 with the detector asserting `illegal_move` → `move_err` in cycle n+2; `pos5` stays 01; `turn` stays 1.
- `move_sel`=12 → `move_err` at n+1; no enable is asserted; the timer is not cleared.
- No input for 20 WAIT cycles → `timeout` pulses at cycle 20 and `turn` toggles. A move at cycle 19 wins over the timeout.
- Nine legal moves with no win → `draw`=1 and state OVER; a further `move_valid` yields no pulse. Then `new_game` → board all 00, `turn`=0, `draw`=0.
- `game_over` raised in SETTLE after the 5th move → OVER; `pos*` frozen; `rst_n` pulse low → all reset values.
